// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer: fetches over a req/ack
// handshake, holds the instruction for decode, and picks the next PC on commit.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        commit,
    input  logic        jr_control,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        addr_err_q, addr_err_d;

    logic [31:0] branch_off;
    logic [31:0] next_pc;

    assign pc_plus4   = pc_q + 32'd4;
    assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    // JR outranks jump, which outranks a taken branch; everything else is sequential.
    always_comb begin
        next_pc = pc_plus4;
        if (jr_control) begin
            next_pc = rs_data;
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        addr_err_d = addr_err_q;
        case (state_q)
            START: state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (commit) begin
                    if (next_pc[1:0] == 2'b00) begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end else begin
                        addr_err_d = 1'b1;
                        state_d    = HALT;
                    end
                end
            end
            HALT:    state_d = HALT;
            default: state_d = START;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= START;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign instr_valid = (state_q == EXEC);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: expected fetch addresses are queued at
// commit time and checked by a monitor whenever a new fetch request appears.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        commit = 1'b0;
    logic        jr_control = 1'b0;
    logic        jump = 1'b0;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] rs_data = 32'd0;
    logic        addr_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_req_cyc = 0;
    logic [31:0] exp_q[$];

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4),
        .commit(commit), .jr_control(jr_control), .jump(jump),
        .branch(branch), .zero(zero), .rs_data(rs_data),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: each new fetch request must target the next queued address.
    initial begin
        logic req_prev;
        logic [31:0] e;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (imem_req === 1'b1 && req_prev !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_fetch: got addr %h expected no request", imem_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("fetch_addr", imem_addr, e);
                    $display("fetch addr=%h expected=%h", imem_addr, e);
                end
            end
            req_prev = imem_req;
        end
    end

    task automatic wait_req(output bit ok);
        int n;
        ok = 1'b1;
        n = 0;
        while (imem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (imem_req !== 1'b1) begin
            ok = 1'b0;
            checks++;
            errors++;
            $display("FAIL req_timeout: got imem_req=%b expected 1 within 50 cycles", imem_req);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_err", {31'd0, addr_err}, 32'd0);
        exp_q.push_back(32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("first_cycle_req", {31'd0, imem_req}, 32'd0);
    endtask

    // One fetch/execute/commit transaction driven from a negedge.
    task automatic do_instr(input logic [31:0] word, input int waits, input bit stray,
                            input bit jr_i, input bit j_i, input bit br_i, input bit z_i,
                            input logic [31:0] rs, input logic [31:0] exp_next, input bit chk_rate);
        bit ok;
        logic [31:0] a0;
        wait_req(ok);
        if (!ok) return;
        if (chk_rate) chk("throughput", cyc - last_req_cyc, 32'd2);
        last_req_cyc = cyc;
        a0 = imem_addr;
        for (int w = 0; w < waits; w++) begin
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, a0);
            chk("wait_valid", {31'd0, instr_valid}, 32'd0);
            @(negedge clk);
        end
        imem_ack = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("instr_valid", {31'd0, instr_valid}, 32'd1);
        chk("instr", instr, word);
        if (stray) begin
            imem_ack = 1'b1;
            imem_rdata = ~word;
            @(negedge clk);
            imem_ack = 1'b0;
            chk("stray_valid", {31'd0, instr_valid}, 32'd1);
            chk("stray_instr", instr, word);
        end
        jr_control = jr_i; jump = j_i; branch = br_i; zero = z_i; rs_data = rs;
        commit = 1'b1;
        if (exp_next[1:0] == 2'b00) exp_q.push_back(exp_next);
        $display("commit pc=%h instr=%h jr=%b j=%b br=%b z=%b rs=%h next=%h",
                 pc, word, jr_i, j_i, br_i, z_i, rs, exp_next);
        @(negedge clk);
        commit = 1'b0; jr_control = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0;
    endtask

    initial begin
        bit ok;
        do_reset();
        // Sequential zero-wait fetch: 0, 4, 8, C.
        do_instr(32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 32'h4, 0);
        do_instr(32'h0000_0001, 0, 0, 0, 0, 0, 0, 0, 32'h8, 1);
        do_instr(32'h0000_0002, 0, 0, 0, 0, 0, 0, 0, 32'hC, 1);
        // Wait states plus stray ack in EXEC; JR to 0x40.
        do_instr(32'h0000_0003, 3, 1, 1, 0, 0, 0, 32'h40, 32'h40, 0);
        // Taken branch back.
        do_instr(32'h1000_FFFE, 0, 0, 0, 0, 1, 1, 0, 32'h3C, 0);
        do_instr(32'h0000_0004, 0, 0, 1, 0, 0, 0, 32'h40, 32'h40, 0);
        // Untaken branch falls through.
        do_instr(32'h1000_FFFE, 0, 0, 0, 0, 1, 0, 0, 32'h44, 0);
        // Jump.
        do_instr(32'h0800_0100, 0, 0, 0, 1, 0, 0, 0, 32'h400, 0);
        // JR wins over jump and taken branch.
        do_instr(32'h0800_0100, 0, 0, 1, 1, 1, 1, 32'h1000, 32'h1000, 0);
        // Wrap-around.
        do_instr(32'h0000_0005, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0);
        do_instr(32'h0000_0006, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        // Misaligned JR from pc 0.
        do_instr(32'h0000_0007, 0, 0, 1, 0, 0, 0, 32'h1002, 32'h1002, 0);
        chk("addr_err", {31'd0, addr_err}, 32'd1);
        chk("halt_pc", pc, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("halt_req", {31'd0, imem_req}, 32'd0);
            @(negedge clk);
        end
        chk("addr_err_sticky", {31'd0, addr_err}, 32'd1);
        // Reset recovers and restarts at RESET_PC.
        do_reset();
        do_instr(32'h0000_0008, 0, 0, 0, 0, 0, 0, 0, 32'h4, 0);
        wait_req(ok);
        // Asynchronous reset between edges during FETCH.
        #2 reset_n = 1'b0;
        #1;
        chk("async_req", {31'd0, imem_req}, 32'd0);
        chk("async_pc", pc, 32'h0);
        chk("async_err", {31'd0, addr_err}, 32'd0);
        do_reset();
        do_instr(32'h0000_0009, 0, 0, 0, 0, 0, 0, 0, 32'h4, 0);
        wait_req(ok);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
